// File: rtl/regfile_scoreboard_if.sv
// Bundles the register-file bus between the pipeline (master) and regfile_scoreboard (slave).
// This covers the read ports, issue handshake, writeback ports, flush and error flag.
interface regfile_scoreboard_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
);
    logic                            FLUSH;
    logic [NUM_READ*ADDR_WIDTH-1:0]  RS_SEL;
    logic [NUM_READ*DATA_WIDTH-1:0]  RS_DOUT;
    logic [NUM_READ-1:0]             RS_BUSY;
    logic                            ISSUE_VALID;
    logic [ADDR_WIDTH-1:0]           ISSUE_RD;
    logic                            ISSUE_READY;
    logic [NUM_WRITE-1:0]            WEN;
    logic [NUM_WRITE-1:0]            WB_CLR;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] RD_SEL;
    logic [NUM_WRITE*DATA_WIDTH-1:0] WB_DATA;
    logic                            SB_ERR;

    modport master (
        output FLUSH, RS_SEL, ISSUE_VALID, ISSUE_RD, WEN, WB_CLR, RD_SEL, WB_DATA,
        input  RS_DOUT, RS_BUSY, ISSUE_READY, SB_ERR
    );

    modport slave (
        input  FLUSH, RS_SEL, ISSUE_VALID, ISSUE_RD, WEN, WB_CLR, RD_SEL, WB_DATA,
        output RS_DOUT, RS_BUSY, ISSUE_READY, SB_ERR
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-through bypass and a saturating
// per-register outstanding-write scoreboard (issue / retire / flush).
module regfile_scoreboard #(
    parameter int              ADDR_WIDTH = 5,
    parameter int              DATA_WIDTH = 32,
    parameter int              NUM_READ   = 2,
    parameter int              NUM_WRITE  = 2,
    parameter int              CNT_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] SP_INIT = 32'h0100_0000,
    parameter logic [DATA_WIDTH-1:0] GP_INIT = 32'h0200_0000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    regfile_scoreboard_if.slave   bus
);
    localparam int unsigned NREG  = 1 << ADDR_WIDTH;
    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs    [NREG];
    logic [CNT_WIDTH-1:0]  cnt     [NREG];
    logic [CNT_WIDTH-1:0]  cnt_nxt [NREG];
    logic [SUM_W-1:0]      dec     [NREG];
    logic [ADDR_WIDTH-1:0] wsel    [NUM_WRITE];
    logic [ADDR_WIDTH-1:0] rsel    [NUM_READ];
    logic [SUM_W-1:0]      sum;
    logic                  accept;
    logic                  err_set;
    logic                  sb_err;

    always_comb begin
        for (int unsigned p = 0; p < NUM_WRITE; p++) begin
            wsel[p] = bus.RD_SEL[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            rsel[k] = bus.RS_SEL[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign bus.ISSUE_READY = (bus.ISSUE_RD == '0) || (cnt[bus.ISSUE_RD] != '1);
    assign accept          = bus.ISSUE_VALID && bus.ISSUE_READY && !bus.FLUSH;
    assign bus.SB_ERR      = sb_err;

    // Per-register retire count, then next count; an underflow clamps to zero and flags.
    always_comb begin
        err_set = 1'b0;
        sum     = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int unsigned p = 0; p < NUM_WRITE; p++) begin
                if (bus.WEN[p] && bus.WB_CLR[p] && wsel[p] == ADDR_WIDTH'(r)) begin
                    dec[r] = dec[r] + SUM_W'(1);
                end
            end
            sum = SUM_W'(cnt[r]) + SUM_W'(accept && bus.ISSUE_RD == ADDR_WIDTH'(r));
            cnt_nxt[r] = '0;
            if (r != 0 && !bus.FLUSH) begin
                if (sum >= dec[r]) begin
                    cnt_nxt[r] = CNT_WIDTH'(sum - dec[r]);
                end else begin
                    err_set = 1'b1;
                end
            end
        end
    end

    // Read ports: stored value, overridden by any same-cycle write (highest port last).
    always_comb begin
        bus.RS_DOUT = '0;
        bus.RS_BUSY = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            if (rsel[k] != '0) begin
                bus.RS_DOUT[k*DATA_WIDTH +: DATA_WIDTH] = regs[rsel[k]];
                for (int unsigned p = 0; p < NUM_WRITE; p++) begin
                    if (bus.WEN[p] && wsel[p] == rsel[k]) begin
                        bus.RS_DOUT[k*DATA_WIDTH +: DATA_WIDTH] =
                            bus.WB_DATA[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                bus.RS_BUSY[k] = SUM_W'(cnt[rsel[k]]) > dec[rsel[k]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            regs[2] <= SP_INIT;
            regs[3] <= GP_INIT;
            sb_err  <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            for (int unsigned p = 0; p < NUM_WRITE; p++) begin
                if (bus.WEN[p] && wsel[p] != '0) begin
                    regs[wsel[p]] <= bus.WB_DATA[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            regs[0] <= '0;
            if (err_set) begin
                sb_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus queues expected values, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_regfile_scoreboard;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        string       name;
        int          kind;   // 0 RS_DOUT, 1 RS_BUSY, 2 ISSUE_READY, 3 SB_ERR
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(2)) bus ();

    regfile_scoreboard #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(2), .CNT_WIDTH(2),
        .SP_INIT(32'h0100_0000), .GP_INIT(32'h0200_0000)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = bus.RS_DOUT[e.port*DW +: DW];
                1:       act = {31'b0, bus.RS_BUSY[e.port]};
                2:       act = {31'b0, bus.ISSUE_READY};
                default: act = {31'b0, bus.SB_ERR};
            endcase
            checks++;
            if (act === e.exp) passed++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
    end

    task automatic expect_v(input string name, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.port = port; e.exp = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        bus.FLUSH = 1'b0; bus.RS_SEL = '0; bus.ISSUE_VALID = 1'b0; bus.ISSUE_RD = '0;
        bus.WEN = '0; bus.WB_CLR = '0; bus.RD_SEL = '0; bus.WB_DATA = '0;
    endtask

    task automatic rd(input int port, input logic [AW-1:0] idx);
        bus.RS_SEL[port*AW +: AW] = idx;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] idx, input logic [31:0] data, input logic retire);
        bus.WEN[port] = 1'b1;
        bus.WB_CLR[port] = retire;
        bus.RD_SEL[port*AW +: AW] = idx;
        bus.WB_DATA[port*DW +: DW] = data;
    endtask

    task automatic issue(input logic [AW-1:0] idx);
        bus.ISSUE_VALID = 1'b1;
        bus.ISSUE_RD = idx;
    endtask

    initial begin
        clr();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        // Reset state
        expect_v("rst_dout", 0, 0, 32'h0);
        expect_v("rst_busy", 1, 0, 32'h0);
        expect_v("rst_ready", 2, 0, 32'h1);
        expect_v("rst_err", 3, 0, 32'h0);
        step();
        rd(0, 2); rd(1, 3);
        expect_v("x2_init", 0, 0, 32'h0100_0000);
        expect_v("x3_init", 0, 1, 32'h0200_0000);
        expect_v("x2_busy", 1, 0, 32'h0);
        step(); clr();
        rd(0, 5);
        expect_v("x5_init", 0, 0, 32'h0);
        wr(1, 0, 32'hFFFF_FFFF, 1'b0);
        rd(1, 0);
        expect_v("x0_bypass", 0, 1, 32'h0);
        step(); clr();
        rd(0, 0);
        expect_v("x0_read", 0, 0, 32'h0);

        // Single producer on x5
        issue(5);
        step(); clr();
        rd(0, 5);
        expect_v("x5_busy", 1, 0, 32'h1);
        step();
        wr(0, 5, 32'hDEAD_BEEF, 1'b1);
        expect_v("x5_bypass", 0, 0, 32'hDEAD_BEEF);
        expect_v("x5_busy_wb", 1, 0, 32'h0);
        step(); clr();
        rd(0, 5);
        expect_v("x5_stored", 0, 0, 32'hDEAD_BEEF);
        expect_v("x5_idle", 1, 0, 32'h0);

        // Dual-port write to x7, higher port wins
        issue(7); step(); issue(7); step(); clr();
        wr(0, 7, 32'h11, 1'b1); wr(1, 7, 32'h22, 1'b1);
        rd(0, 7);
        expect_v("x7_bypass", 0, 0, 32'h22);
        expect_v("x7_busy_wb", 1, 0, 32'h0);
        step(); clr();
        rd(0, 7);
        expect_v("x7_stored", 0, 0, 32'h22);
        expect_v("x7_idle", 1, 0, 32'h0);
        expect_v("x7_err", 3, 0, 32'h0);

        // Saturation on x9
        issue(9);
        expect_v("x9_ready0", 2, 0, 32'h1);
        step(); step(); step();
        issue(9);
        rd(0, 9);
        expect_v("x9_full", 2, 0, 32'h0);
        expect_v("x9_busy", 1, 0, 32'h1);
        step();
        bus.ISSUE_RD = 10;
        expect_v("x10_ready", 2, 0, 32'h1);
        step(); clr();
        bus.ISSUE_RD = 9;
        expect_v("x9_held", 2, 0, 32'h0);
        step();
        wr(0, 9, 32'h99, 1'b1);
        expect_v("x9_retire_same", 2, 0, 32'h0);
        step(); clr();
        bus.ISSUE_RD = 9;
        rd(0, 9);
        expect_v("x9_unblock", 2, 0, 32'h1);
        expect_v("x9_busy2", 1, 0, 32'h1);
        step(); clr();

        // Issue and retire x4 in the same cycle
        issue(4); step(); clr();
        issue(4); wr(0, 4, 32'h44, 1'b1);
        rd(1, 4);
        expect_v("x4_busy_wb", 1, 1, 32'h0);
        expect_v("x4_bypass", 0, 1, 32'h44);
        step(); clr();
        rd(1, 4);
        expect_v("x4_busy_next", 1, 1, 32'h1);
        expect_v("x4_stored", 0, 1, 32'h44);
        step(); clr();

        // Flush with pending producers and a concurrent write
        issue(6); step(); issue(6); step(); clr();
        bus.FLUSH = 1'b1;
        wr(1, 8, 32'h88, 1'b0);
        rd(0, 6);
        expect_v("x6_busy_pre", 1, 0, 32'h1);
        step(); clr();
        rd(0, 6); rd(1, 8);
        expect_v("x6_flushed", 1, 0, 32'h0);
        expect_v("x8_flush_wr", 0, 1, 32'h88);
        step(); clr();
        rd(0, 9); rd(1, 4);
        expect_v("x9_flushed", 1, 0, 32'h0);
        expect_v("x4_flushed", 1, 1, 32'h0);
        wr(0, 6, 32'h66, 1'b1);
        expect_v("err_before", 3, 0, 32'h0);
        step(); clr();
        rd(0, 6);
        expect_v("x6_data", 0, 0, 32'h66);
        expect_v("err_set", 3, 0, 32'h1);
        bus.FLUSH = 1'b1;
        step(); clr();
        expect_v("err_sticky", 3, 0, 32'h1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        rd(0, 6); rd(1, 2);
        expect_v("err_reset", 3, 0, 32'h0);
        expect_v("x6_reset", 0, 0, 32'h0);
        expect_v("x2_reset", 0, 1, 32'h0100_0000);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
            checks = checks + q.size();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
